// File: rtl/stopwatch_defs_pkg.sv
// Shared definitions for the stopwatch control slice.
// Holds the FSM state encoding, the default timing constants for a
// 50 MHz system clock and a counter-width helper.
package stopwatch_defs;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_LAP     = 3'd2,
    ST_STOPPED = 3'd3,
    ST_OVF     = 3'd4
  } sw_state_e;

  localparam int unsigned DEF_CLK_DIV    = 500000;   // 50 MHz -> 100 Hz
  localparam int unsigned DEF_DEB_CYCLES = 1000000;  // 20 ms
  localparam int unsigned DEF_IND_DIV    = 50;       // 1 Hz blink period

  // Bits needed for a counter running 0 .. n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Debouncer for one raw active-low push button.
// Ports:
//   i_clk, i_rst_n : system clock, asynchronous active-low reset
//   i_btn_n        : raw button, asynchronous to i_clk
//   o_level        : debounced level (1 = released)
//   o_press        : registered one-cycle pulse on a debounced 1->0 transition
module button_debounce
  import stopwatch_defs::*;
#(
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn_n,
  output logic o_level,
  output logic o_press
);

  localparam int unsigned    CW      = cnt_width(DEB_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEB_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_press;
  logic [CW-1:0] r_cnt;
  logic          w_differs;
  logic          w_accept;

  assign w_differs = (r_sync2 != r_level);
  // The differing value has been seen for DEB_CYCLES consecutive cycles.
  assign w_accept  = w_differs && (r_cnt == CNT_MAX);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
      // Only a falling (press) acceptance produces an event.
      r_press <= w_accept && !r_sync2;
      if (!w_differs) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control and sequencing block.
// Debounces the start_stop and hold buttons, runs the
// IDLE/RUN/LAP/STOPPED/OVF state machine and generates the counter
// controls and indicators.
// Ports:
//   CLK_50MHz, reset_n : system clock, asynchronous active-low reset
//   start_stop, hold   : raw active-low buttons
//   overflow_in        : counter chain wrap, coincident with count_en
//   count_en           : one-cycle counter increment enable
//   count_clr          : one-cycle synchronous clear to the counter chain
//   disp_freeze        : display latch hold (LAP)
//   run_ind            : high in RUN or LAP
//   overflow_flag      : high in OVF
//   CLK_ind            : toggles every IND_DIV count_en pulses
//   state              : current FSM state (debug)
module stopwatch_ctrl
  import stopwatch_defs::*;
#(
  parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int unsigned IND_DIV    = DEF_IND_DIV
) (
  input  logic       CLK_50MHz,
  input  logic       reset_n,
  input  logic       start_stop,
  input  logic       hold,
  input  logic       overflow_in,
  output logic       count_en,
  output logic       count_clr,
  output logic       disp_freeze,
  output logic       run_ind,
  output logic       overflow_flag,
  output logic       CLK_ind,
  output logic [2:0] state
);

  localparam int unsigned   PW       = cnt_width(CLK_DIV);
  localparam int unsigned   IW       = cnt_width(IND_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IND_MAX   = IW'(IND_DIV - 1);

  sw_state_e     r_state;
  sw_state_e     w_next;
  logic [PW-1:0] r_presc;
  logic [IW-1:0] r_ind_cnt;
  logic          r_clk_ind;
  logic          r_count_clr;
  logic          w_start_press;
  logic          w_hold_press;
  logic          w_unused_start_level;
  logic          w_unused_hold_level;
  logic          w_running;
  logic          w_count_en;
  logic          w_enter_idle;

  button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
    .i_clk   (CLK_50MHz),
    .i_rst_n (reset_n),
    .i_btn_n (start_stop),
    .o_level (w_unused_start_level),
    .o_press (w_start_press)
  );

  button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_hold (
    .i_clk   (CLK_50MHz),
    .i_rst_n (reset_n),
    .i_btn_n (hold),
    .o_level (w_unused_hold_level),
    .o_press (w_hold_press)
  );

  assign w_running    = (r_state == ST_RUN) || (r_state == ST_LAP);
  assign w_count_en   = w_running && (r_presc == PRESC_MAX);
  assign w_enter_idle = (w_next == ST_IDLE) && (r_state != ST_IDLE);

  // Priority: overflow_in, then start press, then hold press.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_start_press) w_next = ST_RUN;
      ST_RUN: begin
        if (overflow_in)        w_next = ST_OVF;
        else if (w_start_press) w_next = ST_STOPPED;
        else if (w_hold_press)  w_next = ST_LAP;
      end
      ST_LAP: begin
        if (overflow_in)        w_next = ST_OVF;
        else if (w_start_press) w_next = ST_STOPPED;
        else if (w_hold_press)  w_next = ST_RUN;
      end
      ST_STOPPED: begin
        if (w_start_press)      w_next = ST_RUN;
        else if (w_hold_press)  w_next = ST_IDLE;
      end
      ST_OVF:     if (w_hold_press) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Prescaler and blink counter only advance while running; they hold in
  // STOPPED/OVF and are cleared on the transition into IDLE.
  always_ff @(posedge CLK_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_presc     <= '0;
      r_ind_cnt   <= '0;
      r_clk_ind   <= 1'b0;
      r_count_clr <= 1'b0;
    end else begin
      r_count_clr <= w_enter_idle;
      if (w_enter_idle) begin
        r_presc   <= '0;
        r_ind_cnt <= '0;
        r_clk_ind <= 1'b0;
      end else if (w_running) begin
        if (w_count_en) begin
          r_presc <= '0;
          if (r_ind_cnt == IND_MAX) begin
            r_ind_cnt <= '0;
            r_clk_ind <= ~r_clk_ind;
          end else begin
            r_ind_cnt <= r_ind_cnt + IW'(1);
          end
        end else begin
          r_presc <= r_presc + PW'(1);
        end
      end
    end
  end

  assign count_en      = w_count_en;
  assign count_clr     = r_count_clr;
  assign disp_freeze   = (r_state == ST_LAP);
  assign run_ind       = w_running;
  assign overflow_flag = (r_state == ST_OVF);
  assign CLK_ind       = r_clk_ind;
  assign state         = r_state;

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control and sequencing block for the stopwatch counter and seven-segment datapath. It debounces the two active-low push buttons (start_stop, hold) and runs the run/lap/stop/clear/overflow state machine. It generates the gated 100 Hz count enable, the counter clear, the display-freeze (lap) control, the overflow flag and the CLK_ind blink. It sits between the board buttons and the BCD counter chain inside the Stopwatch top level.

Parameters:
CLK_DIV, 500000, system cycles per count_en pulse (50 MHz -> 100 Hz); minimum 2
DEB_CYCLES, 1000000, cycles a synchronised button level must stay stable before it is accepted (20 ms); minimum 1
IND_DIV, 50, count_en pulses per clk_ind toggle (1 Hz blink period)

Ports:
CLK_50MHz  in  1  system clock, the single clock of the block
reset_n  in  1  asynchronous active-low reset
start_stop  in  1  raw active-low button, asynchronous to the clock
hold  in  1  raw active-low button, asynchronous to the clock
overflow_in  in  1  high for one cycle, coincident with the count_en that wraps 59:59.99 -> 00:00.00
count_en  out  1  one-cycle counter increment enable
count_clr  out  1  one-cycle synchronous clear to the counter chain
disp_freeze  out  1  display latch holds its last value while high
run_ind  out  1  high in RUN or LAP
overflow_flag  out  1  high in OVF
CLK_ind  out  1  toggles every IND_DIV count_en pulses
state  out  3  current FSM state, for debug

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE, prescaler=0, ind counter=0. All outputs are 0. Debounced levels are 1 (released) and the sync flops are set to 1.
- Debounce, per button: 2-flop synchroniser, then a stability counter. The counter resets whenever the synchronised value equals the debounced level. When it differs for DEB_CYCLES consecutive cycles, the debounced level updates and the counter resets.
- Press event: a 1->0 transition of the debounced level produces a registered one-cycle press pulse. The 0->1 transition (release) generates no event.
- Latency: for a raw edge held stable, the press pulse is high for the cycle after edge 2+DEB_CYCLES. The state changes at edge 3+DEB_CYCLES.
- FSM states: IDLE=0, RUN=1, LAP=2, STOPPED=3, OVF=4.
  - IDLE: start press -> RUN. Hold press is ignored.
  - RUN: overflow_in -> OVF. Otherwise start press -> STOPPED, or hold press -> LAP.
  - LAP: overflow_in -> OVF. Otherwise start press -> STOPPED, or hold press -> RUN.
  - STOPPED: start press -> RUN. Hold press -> IDLE with count_clr.
  - OVF: hold press -> IDLE with count_clr. Start press is ignored.
- Priority, highest first: overflow_in, then start press, then hold press. When start and hold press in the same cycle, only start acts.
- Prescaler: counts only in RUN/LAP, from 0 to CLK_DIV-1. count_en is high in the cycle the prescaler equals CLK_DIV-1 and the state is RUN or LAP; the prescaler then wraps to 0.
  - The prescaler holds its value in STOPPED and OVF, so a resumed run keeps sub-tick phase.
  - It is cleared to 0 on entry to IDLE.
  - The first count_en after IDLE->RUN occurs CLK_DIV cycles after entering RUN.
- count_clr: registered, high for exactly one cycle, the first cycle in IDLE after STOPPED/OVF. Never asserted by reset.
- disp_freeze: 1 in LAP only. Leaving LAP for STOPPED shows the live count.
- OVF: count_en stays 0 and the prescaler is frozen. The counter shows 00:00.00 after the wrap.
- CLK_ind: the ind counter increments on each count_en and wraps at IND_DIV-1, toggling CLK_ind at the wrap. Both are cleared on entry to IDLE. They hold in STOPPED and OVF.
- Reset mid-operation: the reset values above apply immediately. A button held through reset release is seen as a press after debounce.

Decomposition:
- stopwatch_defs package/include holds the state encodings (IDLE..OVF) and the default CLK_DIV/DEB_CYCLES/IND_DIV constants.
- One sub-module, button_debounce (parameter DEB_CYCLES; outputs level and press pulse), instantiated twice.
- The FSM, prescaler and indicator logic live in stopwatch_ctrl.

Test Plan:
(All scenarios use DEB_CYCLES=4, CLK_DIV=5, IND_DIV=2.)
1. Reset, then start_stop low for 10 cycles -> state=RUN at edge 7 after the raw edge. The first count_en comes 5 cycles later, then every 5 cycles. CLK_ind toggles on every 2nd count_en.
2. start_stop glitches low for 3 cycles, then high -> no press, state stays IDLE, count_en never asserts.
3. In RUN, press hold -> state=LAP with disp_freeze=1 and count_en continuing. Press hold again -> RUN with disp_freeze=0. Then press start -> STOPPED, count_en=0, prescaler held. Press start -> RUN, with the next count_en at the remaining prescaler distance.
4. In STOPPED, press hold -> state=IDLE, count_clr high for exactly 1 cycle, prescaler and CLK_ind at 0.
5. In RUN, pulse overflow_in with count_en -> OVF, overflow_flag=1, no further count_en. Start press is ignored. Hold press -> IDLE with count_clr pulse and overflow_flag=0.
6. Start and hold press in the same cycle from RUN -> STOPPED with disp_freeze=0. Then assert reset_n=0 mid-debounce -> all outputs 0 and state=IDLE immediately.
